// File: rtl/dostring_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dostring_pkg : item/mode encodings, palette table and FSM state types
// Revision     : 1.0
// ----------------------------------------------------------------------------
package dostring_pkg;

   localparam logic [1:0] ITEM_START = 2'd0;
   localparam logic [1:0] ITEM_LED   = 2'd1;
   localparam logic [1:0] ITEM_END   = 2'd2;

   localparam logic [1:0] MODE_SOLID = 2'd0;
   localparam logic [1:0] MODE_CHASE = 2'd1;
   localparam logic [1:0] MODE_BLUR  = 2'd2;

   typedef enum logic [1:0] {
      G_WAIT = 2'd0,
      G_GEN  = 2'd1,
      G_DONE = 2'd2
   } gen_state_e;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_FREE = 2'd1,
      S_ACK  = 2'd2,
      S_DONE = 2'd3
   } snd_state_e;

   // Bit c set means channel c (0 = blue, 1 = green, 2 = red) is lit.
   function automatic logic [2:0] palette_mask(input logic [2:0] k);
      logic [2:0] m;
      case (k)
         3'd0:    m = 3'b001;
         3'd1:    m = 3'b010;
         3'd2:    m = 3'b100;
         3'd3:    m = 3'b011;
         3'd4:    m = 3'b101;
         3'd5:    m = 3'b110;
         3'd6:    m = 3'b111;
         default: m = 3'b000;
      endcase
      return m;
   endfunction

   function automatic logic [2:0] next_color(input logic [2:0] k);
      return (k == 3'd6) ? 3'd0 : k + 3'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dostring_blur_kernel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dostring_blur_kernel : per-channel (l + 2c + r) >> 2 smoothing filter
// Revision             : 1.0
// ----------------------------------------------------------------------------
module dostring_blur_kernel #(
   parameter int NUM_CHANNELS = 3,
   parameter int COLOR_W      = 8
) (
   input  logic [NUM_CHANNELS*COLOR_W-1:0] left_i,
   input  logic [NUM_CHANNELS*COLOR_W-1:0] center_i,
   input  logic [NUM_CHANNELS*COLOR_W-1:0] right_i,
   output logic [NUM_CHANNELS*COLOR_W-1:0] blur_o
);

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
      logic [COLOR_W+1:0] sum;
      // Two guard bits hold the worst case 4 * (2^W - 1) without overflow.
      assign sum = {2'b00, left_i[c*COLOR_W +: COLOR_W]}
                 + {1'b0, center_i[c*COLOR_W +: COLOR_W], 1'b0}
                 + {2'b00, right_i[c*COLOR_W +: COLOR_W]};
      assign blur_o[c*COLOR_W +: COLOR_W] = sum[COLOR_W+1:2];
   end

endmodule
`default_nettype wire

// File: rtl/dostring_frame_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// dostring_frame_seq : ping-pong pattern generator and item streamer for doled
// Revision           : 1.0
// ----------------------------------------------------------------------------
module dostring_frame_seq
   import dostring_pkg::*;
#(
   parameter int                 NUM_PIXELS   = 46,
   parameter int                 NUM_CHANNELS = 3,
   parameter int                 COLOR_W      = 8,
   parameter logic [COLOR_W-1:0] LEVEL        = 8'h3f,
   parameter int                 FRAME_DELAY  = 10000000,
   parameter int                 SEED_HOLD    = 8,
   parameter int                 ACK_TIMEOUT  = 1024
) (
   input  logic                            CLK,
   input  logic                            rst_n,
   input  logic [1:0]                      mode,
   output logic [NUM_CHANNELS*COLOR_W-1:0] px_data,
   output logic [1:0]                      px_type,
   output logic                            px_start,
   input  logic                            px_busy,
   output logic                            frame_sent,
   output logic [15:0]                     frame_count,
   output logic                            ack_err
);

   localparam int PXW   = NUM_CHANNELS * COLOR_W;
   localparam int IDXW  = $clog2(NUM_PIXELS);
   localparam int DLYW  = $clog2(FRAME_DELAY + 1);
   localparam int TOW   = $clog2(ACK_TIMEOUT + 1);
   localparam int SEEDW = $clog2(SEED_HOLD + 1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NUM_PIXELS - 1);

   logic [PXW-1:0]   buf_q [2][NUM_PIXELS];
   logic             front_sel_q, front_valid_q, back_ready_q;
   logic             front_valid_d, back_ready_d, swap, fv_clr;

   gen_state_e       gen_q, gen_d;
   logic [DLYW-1:0]  dly_q, dly_d;
   logic [IDXW-1:0]  idx_q, idx_d, chase_q, chase_d, idx_l, idx_r;
   logic [1:0]       mode_q, mode_d;
   logic [2:0]       color_q, color_d, pal_mask;
   logic [SEEDW-1:0] seed_q, seed_d;
   logic             wr_en;
   logic [PXW-1:0]   lit_px, blur_px, gen_px;

   snd_state_e       snd_q, snd_d;
   logic [1:0]       item_q, item_d, px_type_q, px_type_d;
   logic [IDXW-1:0]  led_q, led_d;
   logic [TOW-1:0]   tmo_q, tmo_d;
   logic [PXW-1:0]   px_data_q, px_data_d;
   logic             px_start_q, px_start_d, frame_sent_q, frame_sent_d;
   logic             ack_err_q, ack_err_d;
   logic [15:0]      frame_count_q, frame_count_d;

   // Buffers exchange roles rather than copying; only a finished back buffer
   // may replace a front buffer the sender has released.
   assign swap          = (snd_q == S_IDLE) && !front_valid_q && back_ready_q;
   assign front_valid_d = swap ? 1'b1 : (fv_clr ? 1'b0 : front_valid_q);

   assign pal_mask = palette_mask(color_q);
   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_pal
      if (c < 3) begin : g_rgb
         assign lit_px[c*COLOR_W +: COLOR_W] = pal_mask[c] ? LEVEL : '0;
      end else begin : g_extra
         assign lit_px[c*COLOR_W +: COLOR_W] = '0;
      end
   end

   assign idx_l = idx_q - IDXW'(1);
   assign idx_r = (idx_q == LAST_IDX) ? idx_q : idx_q + IDXW'(1);

   dostring_blur_kernel #(
      .NUM_CHANNELS (NUM_CHANNELS),
      .COLOR_W      (COLOR_W)
   ) u_blur (
      .left_i   (buf_q[front_sel_q][idx_l]),
      .center_i (buf_q[front_sel_q][idx_q]),
      .right_i  (buf_q[front_sel_q][idx_r]),
      .blur_o   (blur_px)
   );

   always_comb begin
      case (mode_q)
         MODE_CHASE: gen_px = (idx_q == chase_q) ? lit_px : '0;
         MODE_BLUR:  gen_px = (idx_q == '0) ? lit_px : blur_px;
         default:    gen_px = lit_px;
      endcase
   end

   always_comb begin
      gen_d        = gen_q;
      dly_d        = dly_q;
      idx_d        = idx_q;
      mode_d       = mode_q;
      color_d      = color_q;
      chase_d      = chase_q;
      seed_d       = seed_q;
      back_ready_d = swap ? 1'b0 : back_ready_q;
      wr_en        = 1'b0;
      case (gen_q)
         G_WAIT: if (!back_ready_q) begin
            if (dly_q == DLYW'(FRAME_DELAY - 1)) begin
               mode_d = mode;
               idx_d  = '0;
               gen_d  = G_GEN;
            end else begin
               dly_d = dly_q + DLYW'(1);
            end
         end
         G_GEN: begin
            wr_en = 1'b1;
            if (idx_q == LAST_IDX) begin
               gen_d        = G_DONE;
               back_ready_d = 1'b1;
               case (mode_q)
                  MODE_CHASE: begin
                     chase_d = (chase_q == LAST_IDX) ? '0 : chase_q + IDXW'(1);
                     if (chase_q == LAST_IDX) color_d = next_color(color_q);
                  end
                  MODE_BLUR: begin
                     seed_d = (seed_q == SEEDW'(SEED_HOLD - 1)) ? '0 : seed_q + SEEDW'(1);
                     if (seed_q == SEEDW'(SEED_HOLD - 1)) color_d = next_color(color_q);
                  end
                  default: color_d = next_color(color_q);
               endcase
            end else begin
               idx_d = idx_q + IDXW'(1);
            end
         end
         G_DONE: if (!back_ready_q) begin
            dly_d = '0;
            gen_d = G_WAIT;
         end
         default: gen_d = G_WAIT;
      endcase
   end

   always_comb begin
      snd_d         = snd_q;
      item_d        = item_q;
      led_d         = led_q;
      tmo_d         = tmo_q;
      px_data_d     = px_data_q;
      px_type_d     = px_type_q;
      px_start_d    = px_start_q;
      frame_sent_d  = 1'b0;
      frame_count_d = frame_count_q;
      ack_err_d     = ack_err_q;
      fv_clr        = 1'b0;
      case (snd_q)
         S_IDLE: if (front_valid_q) begin
            snd_d  = S_FREE;
            item_d = ITEM_START;
            led_d  = '0;
         end
         S_FREE: if (!px_busy) begin
            px_type_d  = item_q;
            px_data_d  = (item_q == ITEM_LED) ? buf_q[front_sel_q][led_q] : '0;
            px_start_d = 1'b1;
            tmo_d      = '0;
            snd_d      = S_ACK;
         end
         S_ACK: if (px_busy) begin
            px_start_d = 1'b0;
            snd_d      = S_FREE;
            case (item_q)
               ITEM_START: begin
                  item_d = ITEM_LED;
                  led_d  = '0;
               end
               ITEM_LED: begin
                  if (led_q == LAST_IDX) item_d = ITEM_END;
                  else                   led_d  = led_q + IDXW'(1);
               end
               default: snd_d = S_DONE;
            endcase
         end else if (tmo_q == TOW'(ACK_TIMEOUT - 1)) begin
            px_start_d = 1'b0;
            ack_err_d  = 1'b1;
            fv_clr     = 1'b1;
            snd_d      = S_IDLE;
         end else begin
            tmo_d = tmo_q + TOW'(1);
         end
         S_DONE: if (!px_busy) begin
            frame_sent_d  = 1'b1;
            frame_count_d = frame_count_q + 16'd1;
            fv_clr        = 1'b1;
            snd_d         = S_IDLE;
         end
         default: snd_d = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < 2; b++)
            for (int i = 0; i < NUM_PIXELS; i++) buf_q[b][i] <= '0;
      end else if (wr_en) begin
         buf_q[~front_sel_q][idx_q] <= gen_px;
      end
   end

   always_ff @(posedge CLK or negedge rst_n) begin
      if (!rst_n) begin
         front_sel_q   <= 1'b0;
         front_valid_q <= 1'b0;
         back_ready_q  <= 1'b0;
         gen_q         <= G_WAIT;
         dly_q         <= '0;
         idx_q         <= '0;
         mode_q        <= MODE_SOLID;
         color_q       <= '0;
         chase_q       <= '0;
         seed_q        <= '0;
         snd_q         <= S_IDLE;
         item_q        <= ITEM_START;
         led_q         <= '0;
         tmo_q         <= '0;
         px_data_q     <= '0;
         px_type_q     <= '0;
         px_start_q    <= 1'b0;
         frame_sent_q  <= 1'b0;
         frame_count_q <= '0;
         ack_err_q     <= 1'b0;
      end else begin
         front_sel_q   <= front_sel_q ^ swap;
         front_valid_q <= front_valid_d;
         back_ready_q  <= back_ready_d;
         gen_q         <= gen_d;
         dly_q         <= dly_d;
         idx_q         <= idx_d;
         mode_q        <= mode_d;
         color_q       <= color_d;
         chase_q       <= chase_d;
         seed_q        <= seed_d;
         snd_q         <= snd_d;
         item_q        <= item_d;
         led_q         <= led_d;
         tmo_q         <= tmo_d;
         px_data_q     <= px_data_d;
         px_type_q     <= px_type_d;
         px_start_q    <= px_start_d;
         frame_sent_q  <= frame_sent_d;
         frame_count_q <= frame_count_d;
         ack_err_q     <= ack_err_d;
      end
   end

   assign px_data     = px_data_q;
   assign px_type     = px_type_q;
   assign px_start    = px_start_q;
   assign frame_sent  = frame_sent_q;
   assign frame_count = frame_count_q;
   assign ack_err     = ack_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dostring_frame_seq.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_dostring_frame_seq : directed frame-content, handshake, timeout and reset checks
// Revision              : 1.0
// ----------------------------------------------------------------------------
module tb_dostring_frame_seq;

   logic        CLK;
   logic        rst_n;
   logic [1:0]  mode;
   logic [23:0] px_data;
   logic [1:0]  px_type;
   logic        px_start;
   logic        px_busy;
   logic        frame_sent;
   logic [15:0] frame_count;
   logic        ack_err;

   logic        busy_en;
   logic        busy_hold;
   logic [25:0] log_a [0:2047];
   int          wr_n = 0;
   int          rd_n = 0;
   int          sent_cnt = 0;
   int          frames_done = 0;
   int          viol = 0;
   int          n_total = 0;
   int          n_bad = 0;

   dostring_frame_seq #(
      .NUM_PIXELS   (4),
      .NUM_CHANNELS (3),
      .COLOR_W      (8),
      .LEVEL        (8'h3f),
      .FRAME_DELAY  (16),
      .SEED_HOLD    (4),
      .ACK_TIMEOUT  (1024)
   ) dut (
      .CLK         (CLK),
      .rst_n       (rst_n),
      .mode        (mode),
      .px_data     (px_data),
      .px_type     (px_type),
      .px_start    (px_start),
      .px_busy     (px_busy),
      .frame_sent  (frame_sent),
      .frame_count (frame_count),
      .ack_err     (ack_err)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Serializer model: busy rises 2 cycles after start is seen and stays up 5.
   initial begin
      int dl;
      int hl;
      dl = 0;
      hl = 0;
      px_busy = 1'b0;
      forever begin
         @(negedge CLK);
         if (!rst_n || !busy_en) begin
            px_busy = 1'b0;
            dl = 0;
            hl = 0;
         end else if (busy_hold) begin
            px_busy = 1'b1;
         end else if (dl > 0) begin
            dl--;
            if (dl == 0) begin
               px_busy = 1'b1;
               hl = 5;
            end
         end else if (hl > 0) begin
            hl--;
            if (hl == 0) px_busy = 1'b0;
         end else begin
            px_busy = 1'b0;
            if (px_start) dl = 2;
         end
      end
   end

   // Logs every issued item and frame_sent sample; flags start coexisting with busy.
   initial begin
      logic start_prev;
      start_prev = 1'b0;
      forever begin
         @(posedge CLK);
         #1;
         if (rst_n) begin
            if (px_start && !start_prev && wr_n < 2048) begin
               log_a[wr_n] = {px_type, px_data};
               wr_n++;
            end
            if (frame_sent) sent_cnt++;
            if (px_start && px_busy) viol++;
         end
         start_prev = px_start;
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #2;
   endtask

   task automatic do_reset(input logic [1:0] m);
      rst_n = 1'b0;
      mode  = m;
      repeat (3) step();
      rd_n        = wr_n;
      frames_done = sent_cnt;
      @(negedge CLK);
      rst_n = 1'b1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check($sformatf("%s_px_data", tag), px_data, 0);
      check($sformatf("%s_px_type", tag), px_type, 0);
      check($sformatf("%s_px_start", tag), px_start, 0);
      check($sformatf("%s_frame_sent", tag), frame_sent, 0);
      check($sformatf("%s_frame_count", tag), frame_count, 0);
      check($sformatf("%s_ack_err", tag), ack_err, 0);
   endtask

   task automatic expect_frame(input string tag, input logic [23:0] p0, input logic [23:0] p1,
                               input logic [23:0] p2, input logic [23:0] p3, input int fc);
      logic [25:0] exp_i [6];
      int k;
      k = 0;
      while (sent_cnt <= frames_done && k < 3000) begin
         step();
         k++;
      end
      check($sformatf("%s_arrived", tag), sent_cnt > frames_done, 1);
      frames_done = sent_cnt;
      exp_i[0] = {2'd0, 24'h0};
      exp_i[1] = {2'd1, p0};
      exp_i[2] = {2'd1, p1};
      exp_i[3] = {2'd1, p2};
      exp_i[4] = {2'd1, p3};
      exp_i[5] = {2'd2, 24'h0};
      check($sformatf("%s_nitems", tag), wr_n - rd_n, 6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("%s_item%0d", tag, i), log_a[rd_n], exp_i[i]);
         rd_n++;
      end
      rd_n = wr_n;
      check($sformatf("%s_count", tag), frame_count, fc);
   endtask

   initial begin
      int k;
      int hi;
      int starts;
      busy_en   = 1'b1;
      busy_hold = 1'b0;
      mode      = 2'd0;
      rst_n     = 1'b1;
      #1 rst_n  = 1'b0;
      repeat (2) step();
      check_outputs_zero("reset");
      @(negedge CLK);
      rst_n = 1'b1;

      // Solid: blue then green.
      expect_frame("solid1", 24'h00003f, 24'h00003f, 24'h00003f, 24'h00003f, 1);
      step();
      check("sent_pulse_width", frame_sent, 0);
      expect_frame("solid2", 24'h003f00, 24'h003f00, 24'h003f00, 24'h003f00, 2);
      check("sent_total", sent_cnt, 2);

      // Chase: lit pixel walks, colour advances on wrap.
      do_reset(2'd1);
      expect_frame("chase1", 24'h00003f, 24'h0, 24'h0, 24'h0, 1);
      expect_frame("chase2", 24'h0, 24'h00003f, 24'h0, 24'h0, 2);
      expect_frame("chase3", 24'h0, 24'h0, 24'h00003f, 24'h0, 3);
      expect_frame("chase4", 24'h0, 24'h0, 24'h0, 24'h00003f, 4);
      expect_frame("chase5", 24'h003f00, 24'h0, 24'h0, 24'h0, 5);

      // Blur from an all-zero initial front buffer.
      do_reset(2'd2);
      expect_frame("blur1", 24'h00003f, 24'h0, 24'h0, 24'h0, 1);
      expect_frame("blur2", 24'h00003f, 24'h00000f, 24'h0, 24'h0, 2);
      expect_frame("blur3", 24'h00003f, 24'h000017, 24'h000003, 24'h0, 3);

      // Busy held high: no start may be issued.
      do_reset(2'd0);
      busy_hold = 1'b1;
      starts = 0;
      for (int i = 0; i < 120; i++) begin
         step();
         if (px_start) starts++;
      end
      check("hold_no_start", starts, 0);
      busy_hold = 1'b0;
      expect_frame("after_hold", 24'h00003f, 24'h00003f, 24'h00003f, 24'h00003f, 1);

      // Timeout with busy tied low, then recovery.
      busy_en = 1'b0;
      do_reset(2'd0);
      k = 0;
      while (!px_start && k < 200) begin
         step();
         k++;
      end
      hi = 0;
      while (px_start && hi < 3000) begin
         hi++;
         step();
      end
      busy_en = 1'b1;
      rd_n = wr_n;
      check("timeout_cycles", hi, 1024);
      check("timeout_ack_err", ack_err, 1);
      check("timeout_no_sent", sent_cnt - frames_done, 0);
      check("timeout_count", frame_count, 0);
      expect_frame("recover", 24'h003f00, 24'h003f00, 24'h003f00, 24'h003f00, 1);
      check("ack_err_sticky", ack_err, 1);

      // Reset in the middle of an LED item.
      do_reset(2'd0);
      expect_frame("pre_rst", 24'h00003f, 24'h00003f, 24'h00003f, 24'h00003f, 1);
      k = 0;
      while ((wr_n - rd_n) < 2 && k < 500) begin
         step();
         k++;
      end
      check("mid_led_reached", (wr_n - rd_n) >= 2, 1);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("mid_rst");
      do_reset(2'd0);
      check("mid_rst_no_sent", sent_cnt - frames_done, 0);
      expect_frame("post_rst", 24'h00003f, 24'h00003f, 24'h00003f, 24'h00003f, 1);

      check("start_vs_busy", viol, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
